// File: rtl/l4_rx_chksum_input_ctrl.sv
// L4 (UDP/TCP over IPv4) RX checksum input controller: prepends the 12-byte
// pseudo-header, realigns the segment behind it and drives the checksum engine.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef PKT_TIMESTAMP_W
`define PKT_TIMESTAMP_W 64
`endif

// state | meaning
// IDLE  | waiting for a header descriptor; command issued on accept
// DATA  | passing segment beats, each output beat = {hold, top USE bytes}
// DRAIN | emitting the held tail bytes of the final input beat
module l4_rx_chksum_input_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = `PKT_TIMESTAMP_W,
  parameter int PAD_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src_chksum_rx_hdr_val,
  input  logic [`IP_ADDR_W-1:0]    src_chksum_rx_src_ip,
  input  logic [`IP_ADDR_W-1:0]    src_chksum_rx_dst_ip,
  input  logic [`TOT_LEN_W-1:0]    src_chksum_rx_l4_len,
  input  logic                     src_chksum_rx_proto_tcp,
  input  logic                     src_chksum_rx_csum_en,
  input  logic [USER_WIDTH-1:0]    src_chksum_rx_timestamp,
  output logic                     chksum_src_rx_hdr_rdy,
  input  logic                     src_chksum_rx_data_val,
  input  logic [DATA_WIDTH-1:0]    src_chksum_rx_data,
  input  logic                     src_chksum_rx_last,
  input  logic [PAD_W-1:0]         src_chksum_rx_padbytes,
  output logic                     chksum_src_rx_data_rdy,
  output logic                     req_cmd_val,
  output logic [7:0]               req_cmd_csum_start,
  output logic [7:0]               req_cmd_csum_offset,
  output logic [15:0]              req_cmd_csum_init,
  output logic                     req_cmd_csum_enable,
  input  logic                     req_cmd_rdy,
  output logic [DATA_WIDTH-1:0]    req_tdata,
  output logic [DATA_WIDTH/8-1:0]  req_tkeep,
  output logic                     req_tval,
  output logic                     req_tlast,
  output logic [USER_WIDTH-1:0]    req_tuser,
  output logic                     req_len_err,
  input  logic                     req_trdy
);
  localparam int DATA_BYTES = DATA_WIDTH/8;
  localparam int HOLD_BYTES = 12;
  localparam int USE_BYTES  = DATA_BYTES - HOLD_BYTES;
  localparam int HOLD_W     = HOLD_BYTES*8;
  localparam int LEN_W      = `TOT_LEN_W;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [PAD_W-1:0]       pad_q, pad_d;
  logic [USER_WIDTH-1:0]  ts_q, ts_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [LEN_W-1:0]       beat_bytes;
  logic [LEN_W-1:0]       cnt_sum;
  logic                   pad_ge_hold;

  assign pad_ge_hold = (32'(src_chksum_rx_padbytes) >= HOLD_BYTES);
  assign beat_bytes  = src_chksum_rx_last ?
                       LEN_W'(DATA_BYTES) - LEN_W'(src_chksum_rx_padbytes) :
                       LEN_W'(DATA_BYTES);
  assign cnt_sum     = cnt_q + beat_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pad_q   <= '0;
      ts_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pad_q   <= pad_d;
      ts_q    <= ts_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d                = IDLE;
    hold_d                 = hold_q;
    pad_d                  = pad_q;
    ts_d                   = ts_q;
    len_d                  = len_q;
    cnt_d                  = cnt_q;
    err_d                  = err_q;
    chksum_src_rx_hdr_rdy  = 1'b0;
    chksum_src_rx_data_rdy = 1'b0;
    req_cmd_val            = 1'b0;
    req_cmd_csum_start     = 8'd0;
    req_cmd_csum_offset    = 8'd0;
    req_cmd_csum_init      = 16'd0;
    req_cmd_csum_enable    = 1'b0;
    req_tdata              = '0;
    req_tkeep              = '1;
    req_tval               = 1'b0;
    req_tlast              = 1'b0;
    req_len_err            = 1'b0;

    case (state_q)
      IDLE: begin
        state_d               = IDLE;
        chksum_src_rx_hdr_rdy = req_cmd_rdy;
        if (src_chksum_rx_hdr_val && req_cmd_rdy) begin
          req_cmd_val         = 1'b1;
          req_cmd_csum_offset = src_chksum_rx_proto_tcp ? 8'd28 : 8'd18;
          req_cmd_csum_enable = src_chksum_rx_csum_en;
          hold_d = {src_chksum_rx_src_ip, src_chksum_rx_dst_ip, 8'h00,
                    (src_chksum_rx_proto_tcp ? 8'd6 : 8'd17), src_chksum_rx_l4_len};
          ts_d    = src_chksum_rx_timestamp;
          len_d   = src_chksum_rx_l4_len;
          cnt_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        state_d                = DATA;
        req_tval               = src_chksum_rx_data_val;
        chksum_src_rx_data_rdy = req_trdy;
        req_tdata = {hold_q, src_chksum_rx_data[DATA_WIDTH-1 -: USE_BYTES*8]};
        // A final beat with >= 12 pad bytes fits entirely behind the hold bytes.
        if (src_chksum_rx_last && pad_ge_hold) begin
          req_tlast   = 1'b1;
          req_tkeep   = {DATA_BYTES{1'b1}} << (32'(src_chksum_rx_padbytes) - HOLD_BYTES);
          req_len_err = (cnt_sum != len_q);
        end
        if (src_chksum_rx_data_val && req_trdy) begin
          cnt_d  = cnt_sum;
          hold_d = src_chksum_rx_data[HOLD_W-1:0];
          if (src_chksum_rx_last) begin
            if (pad_ge_hold) begin
              state_d = IDLE;
            end else begin
              pad_d   = src_chksum_rx_padbytes;
              err_d   = (cnt_sum != len_q);
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        state_d     = DRAIN;
        req_tval    = 1'b1;
        req_tlast   = 1'b1;
        req_tdata   = {hold_q, {(USE_BYTES*8){1'b0}}};
        req_tkeep   = {DATA_BYTES{1'b1}} << (32'(pad_q) + USE_BYTES);
        req_len_err = err_q;
        if (req_trdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs go quiet as soon as reset asserts, ahead of any clock.
    if (rst) begin
      chksum_src_rx_hdr_rdy  = 1'b0;
      chksum_src_rx_data_rdy = 1'b0;
      req_cmd_val            = 1'b0;
      req_tval               = 1'b0;
    end
  end

  assign req_tuser = ts_q;

endmodule

// File: tb/tb_l4_rx_chksum_input_ctrl.sv
// Self-checking bench for l4_rx_chksum_input_ctrl: directed vector table,
// hand-written DRAIN/reset sequences and randomized packets against a byte-stream model.
`timescale 1ns/1ps
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef PKT_TIMESTAMP_W
`define PKT_TIMESTAMP_W 64
`endif

module tb_l4_rx_chksum_input_ctrl;
  localparam int DW = 256;
  localparam int DB = DW/8;
  localparam int UW = `PKT_TIMESTAMP_W;
  localparam int PW = $clog2(DB);

  logic          clk = 1'b0;
  logic          rst;
  logic          hdr_val;
  logic [31:0]   src_ip, dst_ip;
  logic [15:0]   l4_len;
  logic          proto_tcp, csum_en;
  logic [UW-1:0] timestamp;
  logic          hdr_rdy;
  logic          data_val;
  logic [DW-1:0] data;
  logic          last;
  logic [PW-1:0] padbytes;
  logic          data_rdy;
  logic          cmd_val;
  logic [7:0]    cmd_start, cmd_offset;
  logic [15:0]   cmd_init;
  logic          cmd_enable;
  logic          cmd_rdy;
  logic [DW-1:0] tdata;
  logic [DB-1:0] tkeep;
  logic          tval, tlast;
  logic [UW-1:0] tuser;
  logic          len_err;
  logic          trdy;

  always #5 clk = ~clk;

  l4_rx_chksum_input_ctrl #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .PAD_W(PW)) dut (
    .clk(clk), .rst(rst),
    .src_chksum_rx_hdr_val(hdr_val), .src_chksum_rx_src_ip(src_ip),
    .src_chksum_rx_dst_ip(dst_ip), .src_chksum_rx_l4_len(l4_len),
    .src_chksum_rx_proto_tcp(proto_tcp), .src_chksum_rx_csum_en(csum_en),
    .src_chksum_rx_timestamp(timestamp), .chksum_src_rx_hdr_rdy(hdr_rdy),
    .src_chksum_rx_data_val(data_val), .src_chksum_rx_data(data),
    .src_chksum_rx_last(last), .src_chksum_rx_padbytes(padbytes),
    .chksum_src_rx_data_rdy(data_rdy),
    .req_cmd_val(cmd_val), .req_cmd_csum_start(cmd_start),
    .req_cmd_csum_offset(cmd_offset), .req_cmd_csum_init(cmd_init),
    .req_cmd_csum_enable(cmd_enable), .req_cmd_rdy(cmd_rdy),
    .req_tdata(tdata), .req_tkeep(tkeep), .req_tval(tval), .req_tlast(tlast),
    .req_tuser(tuser), .req_len_err(len_err), .req_trdy(trdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one packet and checks every output beat against the concatenated
  // byte stream {pseudo-header, valid segment bytes} cut into DB-byte beats.
  task automatic run_pkt(input bit tcp, input bit en, input logic [15:0] len,
                         input int nbeats, input int last_pad, input bit bp,
                         output int n_out, output logic [31:0] last_keep,
                         output bit last_err, output int offs, output bit enab);
    logic [255:0] beats[$];
    byte unsigned stream[$];
    logic [255:0] od[$];
    logic [31:0]  okp[$];
    bit           ol[$], oe[$];
    logic [31:0]  sip, dip;
    logic [UW-1:0] ts;
    logic [95:0]  ph;
    logic [15:0]  sum;
    logic [255:0] pd, ed, msk;
    logic [31:0]  pk, ek;
    bit           done, prev_stall, consumed, pl, pe;
    int           i, total, exp_out, cnt, bad_stab, bad_data, bad_keep, bad_last;

    n_out = 0; last_keep = '0; last_err = 0; offs = -1; enab = 0;
    sip = $urandom; dip = $urandom; ts = UW'({$urandom, $urandom});
    ph  = {sip, dip, 8'h00, (tcp ? 8'd6 : 8'd17), len};
    for (int b = 11; b >= 0; b--) stream.push_back(ph[b*8 +: 8]);
    sum = '0;
    for (int k = 0; k < nbeats; k++) begin
      logic [255:0] d;
      int v;
      d = rand256();
      beats.push_back(d);
      v = (k == nbeats-1) ? DB - last_pad : DB;
      sum += 16'(v);
      for (int b = DB-1; b >= DB-v; b--) stream.push_back(d[b*8 +: 8]);
    end

    done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      hdr_val = 1; src_ip = sip; dst_ip = dip; l4_len = len;
      proto_tcp = tcp; csum_en = en; timestamp = ts;
      cmd_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cmd_rdy) begin
        chk("hdr_rdy", hdr_rdy, 1);
        chk("cmd_val", cmd_val, 1);
        chk("cmd_offset", cmd_offset, tcp ? 28 : 18);
        chk("cmd_enable", cmd_enable, en);
        chk("cmd_start_init", {cmd_start, cmd_init}, 0);
        offs = cmd_offset; enab = cmd_enable;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL hdr_timeout: no header accept within budget");
      hdr_val = 0;
      return;
    end

    i = 0; done = 0; prev_stall = 0; consumed = 0;
    bad_stab = 0; pd = '0; pk = '0; pl = 0; pe = 0;
    for (int cyc = 0; cyc < nbeats*8 + 200 && !done; cyc++) begin
      @(negedge clk);
      hdr_val = 0; cmd_rdy = 0; timestamp = ~ts;
      if (consumed) data_val = 0;
      consumed = 0;
      if (i < nbeats) begin
        if (!data_val) data_val = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        data     = beats[i];
        last     = (i == nbeats-1);
        padbytes = last ? PW'(last_pad) : PW'(beats[i][7:0]);
      end else begin
        data_val = 0; last = 0;
      end
      trdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && !(tval && tdata === pd && tkeep === pk && tlast === pl && len_err === pe))
        bad_stab++;
      if (tval && trdy) begin
        od.push_back(tdata); okp.push_back(tkeep); ol.push_back(tlast); oe.push_back(len_err);
        if (tlast) begin
          chk("tuser", tuser, ts);
          done = 1;
        end
      end
      prev_stall = tval && !trdy;
      pd = tdata; pk = tkeep; pl = tlast; pe = len_err;
      if (data_val && data_rdy) begin
        i++;
        consumed = 1;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL data_timeout: no tlast handshake within budget");
    end
    chk("stall_stable", bad_stab, 0);

    total   = stream.size();
    exp_out = (total + DB - 1) / DB;
    n_out   = od.size();
    chk("beat_count", n_out, exp_out);
    bad_data = 0; bad_keep = 0; bad_last = 0;
    for (int k = 0; k < n_out && k < exp_out; k++) begin
      cnt = (total - k*DB < DB) ? total - k*DB : DB;
      ek  = 32'hFFFF_FFFF << (DB - cnt);
      ed  = '0;
      for (int b = 0; b < cnt; b++) ed[(DB-1-b)*8 +: 8] = stream[k*DB + b];
      for (int b = 0; b < DB; b++) msk[b*8 +: 8] = {8{ek[b]}};
      if (okp[k] !== ek) bad_keep++;
      if ((od[k] & msk) !== ed) bad_data++;
      if (ol[k] !== (k == exp_out-1)) bad_last++;
    end
    chk("tkeep", bad_keep, 0);
    chk("tdata", bad_data, 0);
    chk("tlast", bad_last, 0);
    if (n_out > 0) begin
      last_keep = okp[n_out-1];
      last_err  = oe[n_out-1];
      chk("len_err", last_err, (sum != len));
    end
  endtask

  typedef struct {
    bit          tcp;
    bit          en;
    int          len;
    int          nbeats;
    int          pad;
    int          exp_off;
    int          exp_nout;
    logic [31:0] exp_keep;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[9];
  int          n_out, offs;
  logic [31:0] lk;
  bit          le, enab;
  logic [255:0] d0, s0;
  logic [95:0]  ph;

  initial begin
    vecs[0] = '{0, 1,   20,    1, 12, 18,    1, 32'hFFFF_FFFF, 0};
    vecs[1] = '{0, 1,   40,    2, 24, 18,    2, 32'hFFFF_F000, 0};
    vecs[2] = '{1, 1,   30,    1,  2, 28,    2, 32'hFFC0_0000, 0};
    vecs[3] = '{0, 1,   40,    1,  0, 18,    2, 32'hFFF0_0000, 1};
    vecs[4] = '{1, 0,   60,    2,  4, 28,    3, 32'hFF00_0000, 0};
    vecs[5] = '{0, 1,    8,    1, 24, 18,    1, 32'hFFFF_F000, 0};
    vecs[6] = '{1, 1,   21,    1, 11, 28,    2, 32'h8000_0000, 0};
    vecs[7] = '{0, 1,    1,    1, 31, 18,    1, 32'hFFF8_0000, 0};
    vecs[8] = '{0, 1,   32, 2049,  0, 18, 2050, 32'hFFF0_0000, 0};

    rst = 1; hdr_val = 0; src_ip = '0; dst_ip = '0; l4_len = '0; proto_tcp = 0;
    csum_en = 0; timestamp = '0; data_val = 0; data = '0; last = 0; padbytes = '0;
    cmd_rdy = 1; trdy = 1;
    #1;
    chk("rst_hdr_rdy", hdr_rdy, 0);
    chk("rst_vals", {cmd_val, tval, data_rdy}, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tkeep", tkeep, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("idle_hdr_rdy", hdr_rdy, 1);

    foreach (vecs[v]) begin
      run_pkt(vecs[v].tcp, vecs[v].en, 16'(vecs[v].len), vecs[v].nbeats, vecs[v].pad, 1'b0,
              n_out, lk, le, offs, enab);
      chk($sformatf("vec%0d_offset", v), offs, vecs[v].exp_off);
      chk($sformatf("vec%0d_nout", v), n_out, vecs[v].exp_nout);
      chk($sformatf("vec%0d_keep", v), lk, vecs[v].exp_keep);
      chk($sformatf("vec%0d_err", v), le, vecs[v].exp_err);
    end

    // DRAIN held for three cycles of backpressure.
    d0 = rand256();
    @(negedge clk);
    hdr_val = 1; src_ip = 32'h0A00_0001; dst_ip = 32'h0A00_0002; l4_len = 16'd30;
    proto_tcp = 1; csum_en = 1; cmd_rdy = 1; trdy = 0; data_val = 0;
    ph = {32'h0A00_0001, 32'h0A00_0002, 8'h00, 8'd6, 16'd30};
    @(negedge clk);
    hdr_val = 0; data_val = 1; data = d0; last = 1; padbytes = PW'(2); trdy = 1;
    #1;
    chk("tcp_beat0_top", tdata[255:160], ph);
    chk("tcp_beat0_low", tdata[159:0], d0[255:96]);
    chk("tcp_beat0_flags", {tval, tlast, tkeep}, {2'b10, 32'hFFFF_FFFF});
    @(negedge clk);
    data = rand256(); trdy = 0;
    #1;
    s0 = tdata;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 3) trdy = 1;
        #1;
      end
      chk($sformatf("drain%0d_ctl", c), {tval, tlast, len_err, data_rdy, hdr_rdy}, 5'b11000);
      chk($sformatf("drain%0d_keep", c), tkeep, 32'hFFC0_0000);
      chk($sformatf("drain%0d_data", c), tdata, s0);
    end
    chk("drain_bytes", tdata[255:176], d0[95:16]);
    @(negedge clk);
    data_val = 0; last = 0; trdy = 1;
    #1;
    chk("drain_to_idle", {hdr_rdy, data_rdy, tval}, 3'b100);

    // Asynchronous reset in the middle of DATA.
    @(negedge clk);
    hdr_val = 1; proto_tcp = 0; l4_len = 16'd64; cmd_rdy = 1; timestamp = UW'(64'h1234);
    @(negedge clk);
    hdr_val = 0; data_val = 1; data = rand256(); last = 0; padbytes = '0; trdy = 1;
    @(negedge clk);
    hdr_val = 1; data = rand256();
    #1;
    chk("pre_rst_active", {tval, data_rdy}, 2'b11);
    #2 rst = 1;
    #1;
    chk("async_rst_vals", {hdr_rdy, data_rdy, cmd_val, tval}, 4'b0000);
    chk("async_rst_tuser", tuser, 0);
    @(negedge clk);
    hdr_val = 0; data_val = 0; trdy = 0;
    @(negedge clk);
    rst = 0;
    run_pkt(1'b0, 1'b0, 16'd40, 2, 24, 1'b0, n_out, lk, le, offs, enab);
    chk("post_rst_enable", enab, 0);
    chk("post_rst_nout", n_out, 2);

    for (int r = 0; r < 25; r++) begin
      int nb, pad;
      logic [15:0] len;
      nb  = $urandom_range(1, 4);
      pad = $urandom_range(0, DB-1);
      len = $urandom_range(0, 1) ? 16'(nb*DB - pad) : 16'($urandom);
      run_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len, nb, pad, 1'b1,
              n_out, lk, le, offs, enab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
